fwd_core_transform: RTL and testbench

FWD_CORE_TRANSFORM -- requirements
Module: fwd_core_transform

---
 rtl/fwd_core_transform.sv | 162 ++++++++++++++++
 tb/tb_fwd_core_transform.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_core_transform.sv
// Forward 4x4 integer core transform: Y = Cf * X * CfT.
// Residual rows stream in one per transfer. Each row is transformed
// horizontally on arrival and stored. The vertical pass is then read out
// one coefficient row per output transfer.
module fwd_core_transform #(
  parameter int MB_SIZE     = 4,
  parameter int PIXEL_WIDTH = 8,
  parameter int COEF_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          src_valid,
  output logic                          src_ready,
  input  logic [PIXEL_WIDTH*MB_SIZE-1:0] residual_in,
  output logic                          dst_valid,
  input  logic                          dst_ready,
  output logic [COEF_WIDTH*MB_SIZE-1:0]  coeff_out,
  output logic [1:0]                    coeff_row,
  output logic                          blk_done
);

  // Horizontal intermediates: |h| <= 6 * 2^(PIXEL_WIDTH-1) fits in PIXEL_WIDTH+3 bits.
  localparam int HW  = PIXEL_WIDTH + 3;
  localparam int HEX = HW - PIXEL_WIDTH;
  localparam int CEX = COEF_WIDTH - HW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [1:0]       row_cnt_q;
  logic [1:0]       coeff_row_q;
  logic             src_ready_q;
  logic             dst_valid_q;
  logic signed [HW-1:0] h_q [4][4];   // h_q[row][col] = horizontal result

  logic             in_xfer;
  logic             out_xfer;
  logic signed [HW-1:0] x_ext [4];
  logic signed [HW-1:0] h_d   [4];
  logic signed [COEF_WIDTH-1:0] v_ext [4][4];
  logic signed [COEF_WIDTH-1:0] y_row [4];

  assign in_xfer  = src_valid & src_ready_q;
  assign out_xfer = dst_valid_q & dst_ready;

  // Horizontal pass on the incoming row: h = x * CfT.
  always_comb begin
    // NOTE: every always_comb output is given a value before any condition so no latch can be inferred.
    for (int j = 0; j < 4; j++) begin
      x_ext[j] = {{HEX{residual_in[PIXEL_WIDTH*j+PIXEL_WIDTH-1]}},
                  residual_in[PIXEL_WIDTH*j +: PIXEL_WIDTH]};
    end
    h_d[0] = x_ext[0] + x_ext[1] + x_ext[2] + x_ext[3];
    h_d[1] = (x_ext[0] <<< 1) + x_ext[1] - x_ext[2] - (x_ext[3] <<< 1);
    h_d[2] = x_ext[0] - x_ext[1] - x_ext[2] + x_ext[3];
    h_d[3] = x_ext[0] - (x_ext[1] <<< 1) + (x_ext[2] <<< 1) - x_ext[3];
  end

  // Vertical pass for the coefficient row currently selected by coeff_row.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        v_ext[r][j] = {{CEX{h_q[r][j][HW-1]}}, h_q[r][j]};
      end
    end
    for (int j = 0; j < 4; j++) begin
      y_row[j] = '0;
      case (coeff_row_q)
        2'd0: y_row[j] = v_ext[0][j] + v_ext[1][j] + v_ext[2][j] + v_ext[3][j];
        2'd1: y_row[j] = (v_ext[0][j] <<< 1) + v_ext[1][j] - v_ext[2][j] - (v_ext[3][j] <<< 1);
        2'd2: y_row[j] = v_ext[0][j] - v_ext[1][j] - v_ext[2][j] + v_ext[3][j];
        default: y_row[j] = v_ext[0][j] - (v_ext[1][j] <<< 1) + (v_ext[2][j] <<< 1) - v_ext[3][j];
      endcase
    end
  end

  // Output packing; coefficients are driven only while a row is being offered.
  always_comb begin
    coeff_out = '0;
    for (int j = 0; j < 4; j++) begin
      coeff_out[COEF_WIDTH*j +: COEF_WIDTH] = dst_valid_q ? y_row[j] : '0;
    end
  end

  assign src_ready = src_ready_q;
  assign dst_valid = dst_valid_q;
  assign coeff_row = coeff_row_q;
  assign blk_done  = out_xfer & (coeff_row_q == 2'd3);

  // Intermediate buffer: store each horizontally transformed row at the row counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this buffer is reset deliberately so a discarded block can never leak into the next one.
      for (int r = 0; r < 4; r++) begin
        for (int j = 0; j < 4; j++) begin
          h_q[r][j] <= '0;
        end
      end
    end else if (in_xfer) begin
      for (int j = 0; j < 4; j++) begin
        h_q[row_cnt_q][j] <= h_d[j];
      end
    end
  end

  // Control FSM with registered handshake outputs and row indices.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      row_cnt_q   <= 2'd0;
      coeff_row_q <= 2'd0;
      src_ready_q <= 1'b0;
      dst_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          src_ready_q <= 1'b1;
          dst_valid_q <= 1'b0;
          if (in_xfer) begin
            row_cnt_q <= 2'd1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          if (in_xfer) begin
            row_cnt_q <= row_cnt_q + 2'd1;
            if (row_cnt_q == 2'd3) begin
              state_q     <= OUT;
              src_ready_q <= 1'b0;
              dst_valid_q <= 1'b1;
              coeff_row_q <= 2'd0;
            end
          end
        end
        OUT: begin
          if (out_xfer) begin
            coeff_row_q <= coeff_row_q + 2'd1;
            if (coeff_row_q == 2'd3) begin
              state_q     <= IDLE;
              row_cnt_q   <= 2'd0;
              dst_valid_q <= 1'b0;
              src_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          row_cnt_q   <= 2'd0;
          coeff_row_q <= 2'd0;
          src_ready_q <= 1'b0;
          dst_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_core_transform.sv
// Self-checking bench for fwd_core_transform: fixed vectors, hand-written
// reset/stall sequences and random blocks against a matrix-product model.
module tb_fwd_core_transform;

  logic        clk;
  logic        reset;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] residual_in;
  logic        dst_valid;
  logic        dst_ready;
  logic [63:0] coeff_out;
  logic [1:0]  coeff_row;
  logic        blk_done;

  int errors = 0;
  int checks = 0;
  int cyc_g  = 0;
  int acc [4];

  typedef int blk_t [16];
  typedef struct {
    string name;
    blk_t  x;
    blk_t  y;
  } vec_t;

  localparam int CF [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};

  fwd_core_transform #(.MB_SIZE(4), .PIXEL_WIDTH(8), .COEF_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .residual_in(residual_in),
    .dst_valid  (dst_valid),
    .dst_ready  (dst_ready),
    .coeff_out  (coeff_out),
    .coeff_row  (coeff_row),
    .blk_done   (blk_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain matrix products Y = Cf * X * Cf^T.
  task automatic model(input blk_t x, output blk_t y);
    int t [4][4];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        t[i][j] = 0;
        for (int k = 0; k < 4; k++) t[i][j] += CF[i][k] * x[k*4+j];
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        y[i*4+j] = 0;
        for (int k = 0; k < 4; k++) y[i*4+j] += t[i][k] * CF[j][k];
      end
  endtask

  task automatic rand_block(output blk_t x);
    for (int i = 0; i < 16; i++) x[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Streams one block in and its four coefficient rows out. src_valid stays
  // high throughout (extra requests must be ignored); dst_ready is lowered
  // for stall_len beats while row stall_row is offered.
  task automatic run_block(input string name, input blk_t x, input blk_t y,
                           input int stall_row, input int stall_len);
    int rin = 0;
    int rout = 0;
    int n = 0;
    int stall_left = stall_len;
    bit loaded = 1'b0;
    while (rout < 4 && n < 100) begin
      @(negedge clk);
      src_valid = 1'b1;
      if (rin < 4) begin
        for (int j = 0; j < 4; j++) residual_in[8*j +: 8] = x[rin*4+j][7:0];
      end else begin
        residual_in = $urandom;
      end
      dst_ready = !(rout == stall_row && stall_left > 0);
      #1;
      if (loaded) begin
        check($sformatf("%s latency", name), int'(dst_valid), 1);
        loaded = 1'b0;
      end
      if (src_ready && rin < 4) begin
        acc[rin] = cyc_g;
        if (rin == 3) loaded = 1'b1;
        rin++;
      end
      if (dst_valid) begin
        check($sformatf("%s src_ready in out", name), int'(src_ready), 0);
        check($sformatf("%s coeff_row", name), int'(coeff_row), rout);
        for (int j = 0; j < 4; j++)
          check($sformatf("%s Y[%0d][%0d]", name, rout, j),
                int'($signed(coeff_out[16*j +: 16])), y[rout*4+j]);
        if (dst_ready) begin
          check($sformatf("%s blk_done row %0d", name, rout), int'(blk_done), int'(rout == 3));
          rout++;
        end else begin
          check($sformatf("%s blk_done stalled", name), int'(blk_done), 0);
          stall_left--;
        end
      end else begin
        check($sformatf("%s blk_done idle", name), int'(blk_done), 0);
      end
      n++;
    end
    check($sformatf("%s rows delivered", name), rout, 4);
  endtask

  initial begin
    vec_t tbl [4];
    blk_t x, y;
    int b1 [4];
    int got;

    tbl[0].name = "dc1";    tbl[0].x = '{default: 1};    tbl[0].y = '{0: 16, default: 0};
    // A lone top-left sample gives Y[i][j] = Cf[i][0] * Cf[j][0].
    tbl[1].name = "impulse"; tbl[1].x = '{0: 1, default: 0};
    tbl[1].y = '{1, 2, 1, 1, 2, 4, 2, 2, 1, 2, 1, 1, 1, 2, 1, 1};
    tbl[2].name = "min";    tbl[2].x = '{default: -128}; tbl[2].y = '{0: -2048, default: 0};
    tbl[3].name = "max";    tbl[3].x = '{default: 127};  tbl[3].y = '{0: 2032, default: 0};

    reset = 1'b1; src_valid = 1'b1; dst_ready = 1'b1; residual_in = 32'h0101_0101;
    repeat (2) @(negedge clk);
    #1;
    check("reset src_ready", int'(src_ready), 0);
    check("reset dst_valid", int'(dst_valid), 0);
    check("reset blk_done", int'(blk_done), 0);
    check("reset coeff_out", int'(coeff_out != 64'd0), 0);
    check("reset coeff_row", int'(coeff_row), 0);
    @(negedge clk);
    reset = 1'b0; src_valid = 1'b0;
    #1 check("src_ready before first edge", int'(src_ready), 0);
    @(negedge clk);
    #1 check("src_ready after first edge", int'(src_ready), 1);
    check("dst_valid after reset", int'(dst_valid), 0);

    // Table vectors, streamed back to back with src_valid held high.
    for (int v = 0; v < 4; v++) begin
      run_block(tbl[v].name, tbl[v].x, tbl[v].y, 9, 0);
      if (v == 0) b1 = acc;
      if (v == 1)
        for (int i = 0; i < 4; i++) begin
          check($sformatf("b2b blk1 accept %0d", i), b1[i] - b1[0], i);
          check($sformatf("b2b blk2 accept %0d", i), acc[i] - b1[0], 8 + i);
        end
    end

    // Five-beat stall on coefficient row 1.
    rand_block(x); model(x, y);
    run_block("stall", x, y, 1, 5);

    // Reset after two accepted rows; the next block must be clean.
    got = 0;
    for (int n = 0; n < 20 && got < 2; n++) begin
      @(negedge clk);
      src_valid = 1'b1; residual_in = $urandom; dst_ready = 1'b1;
      #1;
      if (src_ready) got++;
    end
    check("partial rows accepted", got, 2);
    @(negedge clk);
    src_valid = 1'b0; reset = 1'b1;
    #1 check("mid-load reset src_ready", int'(src_ready), 0);
    check("mid-load reset dst_valid", int'(dst_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    run_block("after reset", tbl[0].x, tbl[0].y, 9, 0);

    // Random blocks with random stalls.
    for (int b = 0; b < 12; b++) begin
      rand_block(x); model(x, y);
      run_block($sformatf("rand%0d", b), x, y, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    src_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
